divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 131 +++++++++++++
 tb/tb_divider.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Iterative RV32M divider: one restoring step per cycle, with single-cycle
// fast paths for divide-by-zero and signed overflow.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] r
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [1:0]       fn_q, fn_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic             in_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_shift, trial;
  logic             ge;
  logic [WIDTH-1:0] step_rem, step_quo, quo_fix, rem_fix;

  assign in_signed = ~funct3[0];
  assign abs_a     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (in_signed && b[WIDTH-1]) ? -b : b;

  // Partial remainder needs one extra bit: after the shift it may exceed 2^WIDTH-1.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign ge        = (rem_shift >= {1'b0, dvs_q});
  assign step_rem  = ge ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign step_quo  = {quo_q[WIDTH-2:0], ge};
  assign quo_fix   = (!fn_q[0] && (neg_a_q ^ neg_b_q)) ? -step_quo : step_quo;
  assign rem_fix   = (!fn_q[0] && neg_a_q) ? -step_rem : step_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    fn_d    = fn_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (ena && funct3[2]) begin
          fn_d    = funct3[1:0];
          neg_a_d = in_signed & a[WIDTH-1];
          neg_b_d = in_signed & b[WIDTH-1];
          rem_d   = '0;
          quo_d   = abs_a;
          dvs_d   = abs_b;
          if (b == '0) begin
            state_d = DONE;
            r_d     = funct3[1] ? a : '1;
          end else if (in_signed && a == MIN_NEG && b == '1) begin
            state_d = DONE;
            r_d     = funct3[1] ? '0 : MIN_NEG;
          end else begin
            state_d = CALC;
            cnt_d   = 6'd32;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = DONE;
          r_d     = fn_q[1] ? rem_fix : quo_fix;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      fn_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      fn_q    <= fn_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign r     = r_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the RV32M divider: normal path, fast
// paths, latency, ignored requests while busy, and mid-operation reset.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  funct3;
  logic        busy;
  logic        valid;
  logic [31:0] r;

  int tests = 0;
  int failures = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .a     (a),
    .b     (b),
    .funct3(funct3),
    .busy  (busy),
    .valid (valid),
    .r     (r)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request, then scrambles the operands while busy and waits for valid.
  task automatic applyStimulus(input logic [2:0] fn, input logic [31:0] aa, input logic [31:0] bb,
                               output int lat, output logic [31:0] res);
    @(negedge clk);
    ena = 1'b1; funct3 = fn; a = aa; b = bb;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = r;
  endtask

  task automatic runOp(input string tag, input logic [2:0] fn, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] exp_r, input int exp_lat);
    int lat;
    logic [31:0] res;
    applyStimulus(fn, aa, bb, lat, res);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_r"}, res, exp_r);
  endtask

  initial begin
    int cyc;
    int seen_valid;
    rst = 1'b1; ena = 1'b0; a = '0; b = '0; funct3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_valid", {31'b0, valid}, 32'd0);
    checkOutput("rst_r", r, 32'd0);
    rst = 1'b0;

    // Non-M funct3 must not start anything
    ena = 1'b1; funct3 = 3'b001; a = 32'd10; b = 32'd2;
    @(negedge clk);
    ena = 1'b0;
    checkOutput("nonm_busy", {31'b0, busy}, 32'd0);

    runOp("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
    @(negedge clk);
    checkOutput("pulse_valid", {31'b0, valid}, 32'd0);
    checkOutput("pulse_busy", {31'b0, busy}, 32'd0);
    checkOutput("hold_r", r, 32'd14);

    runOp("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 33);
    runOp("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    runOp("rem_m7_2", F_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    runOp("rem_7_m2", F_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    runOp("div_100_m7", F_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    runOp("rem_m100_7", F_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
    runOp("divu_big_1", F_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    runOp("divu_big_big", F_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 33);
    runOp("remu_big_10", F_REMU, 32'hFFFFFFFF, 32'd10, 32'd5, 33);
    runOp("divu_0_5", F_DIVU, 32'd0, 32'd5, 32'd0, 33);
    runOp("rem_0_5", F_REM, 32'd0, 32'd5, 32'd0, 33);

    runOp("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    // A request presented during DONE is dropped
    ena = 1'b1; funct3 = F_DIVU; a = 32'd1; b = 32'd1;
    @(negedge clk);
    ena = 1'b0;
    checkOutput("done_ena_busy", {31'b0, busy}, 32'd0);
    runOp("rem_m16_0", F_REM, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 1);
    runOp("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    runOp("rem_ovf", F_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // New request while busy is ignored
    @(negedge clk);
    ena = 1'b1; funct3 = F_DIVU; a = 32'd1000; b = 32'd10;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    cyc = 1;
    checkOutput("busy_calc", {31'b0, busy}, 32'd1);
    while (cyc < 4) begin @(negedge clk); cyc++; end
    ena = 1'b1; funct3 = F_DIVU; a = 32'd50; b = 32'd5;
    @(negedge clk); cyc++;
    ena = 1'b0;
    while (valid !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
    checkOutput("ignore_lat", cyc, 32'd33);
    checkOutput("ignore_r", r, 32'd100);

    // Reset mid-CALC aborts without a valid pulse
    @(negedge clk);
    ena = 1'b1; funct3 = F_DIVU; a = 32'd1000; b = 32'd10;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    cyc = 1;
    while (cyc < 9) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_r", r, 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) seen_valid++;
    end
    checkOutput("abort_no_valid", seen_valid, 32'd0);
    runOp("after_rst", F_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
